instr_sequencer: RTL
====================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, the data_var, register and out_data width.
REQ-002 SHALL have parameter INSTR_W, default 9, the instruction word width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port run  input  1  level; starts execution from IDLE.
REQ-006 SHALL have port instruction  input  INSTR_W  current instruction word from the upstream instruction store.
REQ-007 SHALL have port data_var  input  DATA_W  immediate operand paired with instruction.
REQ-008 SHALL have port step  output  1  registered single-cycle pulse that advances the instruction store address.
REQ-009 SHALL have port out_data  output  DATA_W  value written by OUT.
REQ-010 SHALL have port out_valid  output  1  single-cycle pulse qualifying out_data.
REQ-011 SHALL have port carry  output  1  carry/borrow flag from the last ADD/SUB.
REQ-012 SHALL have port halted  output  1  high while in HALT.
REQ-013 SHALL have port instr_count  output  8  number of executed instructions, modulo 256.

Function
REQ-014 SHALL decode instruction as: [8] halt, [7:5] opcode, [4:3] dst, [2:1] src, [0] imm (1 selects data_var, 0 selects register src).
REQ-015 SHALL hold four DATA_W registers R0-R3.
REQ-016 SHALL implement opcodes: 000 NOP; 001 LOAD dst<=data_var; 010 ADD dst<=dst+op; 011 SUB dst<=dst-op; 100 AND; 101 OR; 110 MOV dst<=R[src]; 111 OUT out_data<=R[dst] with out_valid=1.
REQ-017 SHALL treat instruction[8]=1 as HALT regardless of bits [7:0].
REQ-018 SHALL use FSM states IDLE, SETTLE, EXECUTE, STEP, HALT.
REQ-019 IDLE SHALL go to SETTLE when run=1 and stay otherwise.
REQ-020 SETTLE SHALL last one cycle, capture instruction and data_var into internal registers, and go to EXECUTE.
REQ-021 EXECUTE SHALL go to HALT if the captured halt bit is 1 without changing registers, count or step.
REQ-022 Otherwise EXECUTE SHALL apply the operation and increment instr_count, which wraps from 255 to 0.
REQ-023 After a non-halt EXECUTE, the FSM SHALL go to STEP.
REQ-024 STEP SHALL drive step=1 for exactly that cycle and go to SETTLE; step SHALL be 0 in all other states.
REQ-025 Each non-halt instruction SHALL take exactly 3 cycles.
REQ-026 Operations SHALL compute DATA_W-bit results with wrap-around.
REQ-027 ADD SHALL set carry to the bit-DATA_W carry-out.
REQ-028 SUB SHALL set carry=1 on borrow, i.e. when dst < op unsigned.
REQ-029 All other opcodes SHALL leave carry unchanged.
REQ-030 out_valid SHALL pulse only in the cycle after an EXECUTE of OUT.
REQ-031 out_data SHALL hold its value until the next OUT.
REQ-032 run SHALL be sampled only in IDLE; deasserting it mid-program SHALL have no effect.
REQ-033 HALT SHALL be terminal: halted=1, step=0, and only reset exits it.
REQ-034 When dst equals src, the operation SHALL read the pre-update register value.

Reset
REQ-035 Reset SHALL asynchronously force state=IDLE, R0-R3=0, step=0, out_valid=0, out_data=0, carry=0, halted=0 and instr_count=0.
REQ-036 Reset asserted mid-instruction SHALL abort the instruction with no partial register update and no step pulse.
REQ-037 The block SHALL NOT reset the upstream store; the system SHALL reset both together.

Structure
REQ-038 A shared package SHALL hold the opcode constants, FSM state encoding, DATA_W and INSTR_W, and the instruction field bit positions.
REQ-039 A single combinational sub-module cpu_alu SHALL take op, a, b and return result and carry.

Verification
REQ-040 Reset with run=0 for 10 cycles -> state IDLE, step never pulses, all outputs 0.
REQ-041 LOAD R1,0x0005 then OUT R1 then HALT word 9'b100000000 -> out_data=0x0005 with one out_valid pulse, exactly 2 step pulses 3 cycles apart, halted=1, instr_count=2.
REQ-042 LOAD R0,0xFFFF then ADD R0 imm 0x0001 -> R0=0x0000, carry=1.
REQ-043 Subsequent SUB R0 imm 0x0001 -> R0=0xFFFF, carry=1.
REQ-044 Then AND R0 imm 0x00F0 -> R0=0x00F0, carry unchanged.
REQ-045 Reset asserted during EXECUTE of LOAD R2,0x1234 -> R2=0, no step pulse, state IDLE.
REQ-046 257 NOPs -> instr_count wraps to 1, and step pulses 257 times.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: widths, instruction
// field positions, opcode constants and FSM state encoding.
package instr_sequencer_pkg;

    localparam int DATA_W  = 16;
    localparam int INSTR_W = 9;

    localparam int HALT_BIT = 8;
    localparam int OP_MSB   = 7;
    localparam int OP_LSB   = 5;
    localparam int DST_MSB  = 4;
    localparam int DST_LSB  = 3;
    localparam int SRC_MSB  = 2;
    localparam int SRC_LSB  = 1;
    localparam int IMM_BIT  = 0;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_MOV  = 3'b110,
        OP_OUT  = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_STEP    = 3'd3,
        ST_HALT    = 3'd4
    } state_e;

endpackage

// File: rtl/instr_sequencer_cpu_alu.sv
// Combinational ALU: wrap-around arithmetic/logic on two operands; carry is
// the ADD carry-out or the SUB borrow and is 0 for every other opcode.
module cpu_alu #(
    parameter int DATA_W = 16
) (
    input  instr_sequencer_pkg::opcode_e op,
    input  logic [DATA_W-1:0]            a,
    input  logic [DATA_W-1:0]            b,
    output logic [DATA_W-1:0]            result,
    output logic                         carry
);
    import instr_sequencer_pkg::*;

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    // The extra top bit of the widened difference is exactly the unsigned borrow.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = a;
        carry  = 1'b0;
        case (op)
            OP_LOAD: result = b;
            OP_ADD:  begin result = sum[DATA_W-1:0];  carry = sum[DATA_W];  end
            OP_SUB:  begin result = diff[DATA_W-1:0]; carry = diff[DATA_W]; end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_MOV:  result = b;
            default: result = a;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: SETTLE captures the word, EXECUTE applies
// it, STEP pulses the store address; a halt word parks the FSM in HALT.
module instr_sequencer #(
    parameter int DATA_W  = instr_sequencer_pkg::DATA_W,
    parameter int INSTR_W = instr_sequencer_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [INSTR_W-1:0] instruction,
    input  logic [DATA_W-1:0]  data_var,
    output logic               step,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    output logic               carry,
    output logic               halted,
    output logic [7:0]         instr_count
);
    import instr_sequencer_pkg::*;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   regs_q [4];
    logic [DATA_W-1:0]   regs_d [4];
    logic                carry_q, carry_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                step_q, step_d;
    logic                halted_q, halted_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [DATA_W-1:0]   dvar_q, dvar_d;

    opcode_e             op;
    logic [1:0]          dst;
    logic [1:0]          src;
    logic [DATA_W-1:0]   operand;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_carry;

    assign op  = opcode_e'(instr_q[OP_MSB:OP_LSB]);
    assign dst = instr_q[DST_MSB:DST_LSB];
    assign src = instr_q[SRC_MSB:SRC_LSB];

    // LOAD always takes the immediate and MOV always the register, whatever the imm bit says.
    always_comb begin
        operand = instr_q[IMM_BIT] ? dvar_q : regs_q[src];
        if (op == OP_LOAD) operand = dvar_q;
        if (op == OP_MOV)  operand = regs_q[src];
    end

    cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op),
        .a      (regs_q[dst]),
        .b      (operand),
        .result (alu_result),
        .carry  (alu_carry)
    );

    always_comb begin
        state_d     = state_q;
        regs_d      = regs_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        step_d      = 1'b0;
        halted_d    = halted_q;
        instr_d     = instr_q;
        dvar_d      = dvar_q;
        case (state_q)
            ST_IDLE: if (run) state_d = ST_SETTLE;
            ST_SETTLE: begin
                instr_d = instruction;
                dvar_d  = data_var;
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (instr_q[HALT_BIT]) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end else begin
                    case (op)
                        OP_ADD, OP_SUB: begin
                            regs_d[dst] = alu_result;
                            carry_d     = alu_carry;
                        end
                        OP_LOAD, OP_AND, OP_OR, OP_MOV: regs_d[dst] = alu_result;
                        OP_OUT: begin
                            out_data_d  = regs_q[dst];
                            out_valid_d = 1'b1;
                        end
                        default: ;
                    endcase
                    cnt_d   = cnt_q + 8'd1;
                    step_d  = 1'b1;
                    state_d = ST_STEP;
                end
            end
            ST_STEP: state_d = ST_SETTLE;
            ST_HALT: halted_d = 1'b1;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            regs_q      <= '{default: '0};
            carry_q     <= 1'b0;
            cnt_q       <= 8'd0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            step_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            regs_q      <= regs_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            step_q      <= step_d;
            halted_q    <= halted_d;
        end
    end

    // Captured instruction/operand are only read in EXECUTE, after SETTLE has loaded them.
    always_ff @(posedge clk) begin
        instr_q <= instr_d;
        dvar_q  <= dvar_d;
    end

    assign step        = step_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign carry       = carry_q;
    assign halted      = halted_q;
    assign instr_count = cnt_q;

endmodule
